// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default parameters for the PLL reset/clock-enable sequencer.
package pllseq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pllseq_state_t;

    localparam int unsigned DEF_LOCK_CYCLES = 1024;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_PIX_DIV     = 6;
    localparam int unsigned DEF_CPU_DIV     = 12;

endpackage

// File: rtl/pll_reset_seq_ce_div.sv
// Clock-enable divider: one-cycle pulse every DIV clocks while run is high.
module ce_div #(
    parameter int unsigned DIV = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic ce
);

    localparam int unsigned W = $clog2(DIV);

    logic [W-1:0] cnt_q;
    logic         at_top;

    assign at_top = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_q <= '0;
        end else if (at_top) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ce = run && at_top;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier, core reset sequencer and clock-enable generator.
// Optional saturating lock-loss counter enabled by PLLSEQ_LOSS_COUNT_EN.
module pll_reset_seq
    import pllseq_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned PIX_DIV     = DEF_PIX_DIV,
    parameter int unsigned CPU_DIV     = DEF_CPU_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       sys_rst,
    output logic       ready,
    output logic       ce_pix,
`ifdef PLLSEQ_LOSS_COUNT_EN
    output logic       ce_cpu,
    output logic [7:0] loss_cnt
`else
    output logic       ce_cpu
`endif
);

    localparam int unsigned LW = $clog2(LOCK_CYCLES);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    pllseq_state_t  state_q;
    logic           sync1_q;
    logic           sync2_q;
    logic [LW-1:0]  lock_cnt_q;
    logic [HW-1:0]  hold_cnt_q;
    logic           run;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (sync2_q) begin
                        state_q    <= STABLE;
                        lock_cnt_q <= '0;
                    end
                end
                STABLE: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LOCK;
                    end else if (lock_cnt_q == LW'(LOCK_CYCLES - 1)) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LOCK;
                    end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                        state_q <= RUN;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LOCK;
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign sys_rst = (state_q != RUN);
    assign ready   = (state_q == RUN);
    // Dividers are held cleared outside HOLD/RUN, so both start from zero on HOLD entry.
    assign run     = (state_q == HOLD) || (state_q == RUN);

    ce_div #(.DIV(PIX_DIV)) u_pix (
        .clk (clk),
        .rst (rst),
        .run (run),
        .ce  (ce_pix)
    );

    ce_div #(.DIV(CPU_DIV)) u_cpu (
        .clk (clk),
        .rst (rst),
        .run (run),
        .ce  (ce_cpu)
    );

`ifdef PLLSEQ_LOSS_COUNT_EN
    logic [7:0] loss_q;

    // Only losses out of HOLD or RUN count; STABLE drop-outs are routine during lock-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (run && !sync2_q && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset and clock-enable sequencer directly downstream of the system PLL. Synchronises the PLL `locked` flag into the 36 MHz core clock domain and qualifies it for a fixed stability window. It then holds the core in reset for a further window while the divided clock enables already run, and releases reset. Any lock loss re-enters the sequence; all core logic is clocked by `clk` and advanced by the enables produced here.

## Interface
- `LOCK_CYCLES`, 1024: consecutive synchronised-lock cycles required before reset hold starts (≥2).
- `HOLD_CYCLES`, 16: cycles reset stays asserted with enables running (≥1).
- `PIX_DIV`, 6: `ce_pix` divide ratio (36 MHz → 6 MHz) (≥2).
- `CPU_DIV`, 12: `ce_cpu` divide ratio (36 MHz → 3 MHz) (≥2).
- `clk` in 1: core clock, 36 MHz PLL output.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock flag, asynchronous to `clk`.
- `sys_rst` out 1: core reset, active-high.
- `ready` out 1: high only in RUN.
- `ce_pix` out 1: one-cycle pulse every `PIX_DIV` clocks.
- `ce_cpu` out 1: one-cycle pulse every `CPU_DIV` clocks.
- `loss_cnt` out 8: saturating lock-loss count (only with `PLLSEQ_LOSS_COUNT_EN`).

## Operation
- `locked` passes through a two-flop synchroniser (`sync1`, `sync2`). `locked_s` = `sync2`.
- States:
  - WAIT_LOCK: leaves to STABLE, lock counter = 0, when `locked_s`=1.
  - STABLE: if `locked_s`=0, returns to WAIT_LOCK. Otherwise, when lock counter = `LOCK_CYCLES`-1, goes to HOLD with hold counter = 0 and both divider counters = 0. Otherwise increments the lock counter.
  - HOLD: if `locked_s`=0, goes to WAIT_LOCK. Otherwise, when hold counter = `HOLD_CYCLES`-1, goes to RUN. Otherwise increments the hold counter.
  - RUN: if `locked_s`=0, goes to WAIT_LOCK. Otherwise stays.
- `sys_rst` = (state ≠ RUN); `ready` = (state = RUN). Both are decoded from the state register.
- Divider counters run only in HOLD and RUN. They are held at 0 in WAIT_LOCK and STABLE.
  - Each counter wraps `DIV`-1 → 0.
  - The enable is high while the counter = `DIV`-1 and the state is HOLD or RUN.
- Counter widths: `$clog2` of the respective max. Lock/hold counters do not wrap; the transition fires first.
- Reset (`rst`=1 at an edge):
  - state → WAIT_LOCK; sync flops, all counters → 0.
  - Resulting outputs: `sys_rst`=1, `ready`=0, `ce_pix`=`ce_cpu`=0.
  - Reset mid-RUN asserts `sys_rst` from the next edge.

## Timing
- Let E0 be the first edge sampling `locked`=1.
  - `sync2`=1 after E1; STABLE entered at E2.
  - HOLD entered at E(2+`LOCK_CYCLES`); RUN entered at E(2+`LOCK_CYCLES`+`HOLD_CYCLES`).
  - `sys_rst` falls after that edge.
- First `ce_pix` is high in the cycle after edge E(2+`LOCK_CYCLES`+`PIX_DIV`-1); likewise for `ce_cpu` with `CPU_DIV`.
- Lock loss: first edge sampling `locked`=0 is F0; WAIT_LOCK is entered at F2. From F2: `sys_rst`=1, `ready`=0, enables 0, divider counters cleared.
- Glitch handling: a low pulse on `locked` shorter than one clock period that is not sampled is ignored. A sampled low restarts the full sequence.
- `rst` has priority over all state transitions.

## Configuration
- `PLLSEQ_LOSS_COUNT_EN` defined:
  - `loss_cnt` port exists. It increments by 1 on every HOLD→WAIT_LOCK or RUN→WAIT_LOCK transition caused by `locked_s`=0, saturating at 255.
  - It is cleared only by `rst`.
  - STABLE→WAIT_LOCK does not count.
- Undefined: `loss_cnt` port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `pllseq_pkg`: state enum `pllseq_state_t` (WAIT_LOCK, STABLE, HOLD, RUN) and default parameter constants.
- One sub-module, `ce_div`.
  - Parameter `DIV`; ports `clk`, `rst`, `run`, `ce`.
  - Counter cleared when `run`=0; instantiated twice, for pix and cpu.

## Test plan
Unless stated, parameters are `LOCK_CYCLES`=8, `HOLD_CYCLES`=4, `PIX_DIV`=6, `CPU_DIV`=12.
- Power-up: `rst`=1 for 3 cycles with `locked`=1, then `rst`=0 → `sys_rst`=1 until edge E14 counted from the first post-reset edge, then 0. `ready` rises at the same edge.
- Enable cadence: in RUN for 120 cycles → exactly 20 `ce_pix` and 10 `ce_cpu` pulses, each one cycle wide. First `ce_pix` 5 cycles after HOLD entry.
- Unstable lock: `locked` high for 5 cycles, low 1 cycle, then high → sequence restarts. `sys_rst` never falls before 14 edges after the final rise.
- Lock loss in RUN: `locked` drops → exactly 2 edges later `sys_rst`=1, `ready`=0, enables 0. Re-lock repeats the 14-edge sequence.
- Lock loss in HOLD: drop `locked` during HOLD → WAIT_LOCK. With `PLLSEQ_LOSS_COUNT_EN`, `loss_cnt` goes 0→1; 300 induced RUN losses → `loss_cnt`=255.
- Sync reset mid-RUN: `rst`=1 for one edge while `locked`=1 → `sys_rst`=1 from that edge, divider counters restart. RUN is re-entered 14 edges after `rst` falls.
